// File: rtl/polar_enc_pkg.sv
// Shared definitions for the sequential polar encoder: FSM encodings,
// default code-length limits and the frame beat-count helper.
package polar_enc_pkg;

    localparam int NMAX_LOG_DEF = 10;
    localparam int NMIN_LOG_DEF = 5;

    typedef logic [1:0] state_e;
    localparam state_e IDLE   = 2'd0;
    localparam state_e LOAD   = 2'd1;
    localparam state_e ENCODE = 2'd2;
    localparam state_e EMIT   = 2'd3;

    function automatic int nbeats(input logic [3:0] n, input int p);
        return (1 << n) / p;
    endfunction

endpackage

// File: rtl/polar_encoder_seq_if.sv
// Start, u-input and x-output handshakes plus status for polar_encoder_seq.
interface polar_encoder_seq_if #(
    parameter int P = 32
);
    logic         start_valid;
    logic         start_ready;
    logic [3:0]   n;
    logic         in_valid;
    logic [P-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [P-1:0] out_data;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         err;

    modport master (
        output start_valid, n, in_valid, in_data, out_ready,
        input  start_ready, in_ready, out_valid, out_data, out_last, busy, err
    );

    modport slave (
        input  start_valid, n, in_valid, in_data, out_ready,
        output start_ready, in_ready, out_valid, out_data, out_last, busy, err
    );
endinterface

// File: rtl/polar_enc_stage.sv
// One in-place Arikan butterfly stage: y[i] = x[i] ^ x[i + 2^s] where bit s of i is 0.
module polar_enc_stage #(
    parameter int NMAX_LOG = 10
) (
    input  logic [(1 << NMAX_LOG)-1:0] x,
    input  logic [3:0]                 s,
    output logic [(1 << NMAX_LOG)-1:0] y
);
    localparam int W = 1 << NMAX_LOG;

    always_comb begin
        y = x;
        for (int i = 0; i < W; i++) begin
            if ((((i >> s) & 1) == 0) && ((i + (1 << s)) < W)) begin
                y[i] = x[i] ^ x[i + (1 << s)];
            end
        end
    end
endmodule

// File: rtl/polar_encoder_seq.sv
// Sequential polar encoder x = u * F^{(x)n}: load u in P-bit beats, one butterfly
// stage per cycle, stream x out. POLAR_ENC_RANGE_CHK_EN rejects illegal n instead of clamping.
//
// state  | meaning
// IDLE   | waiting for a start handshake
// LOAD   | accepting u beats into the buffer
// ENCODE | applying stage s_q to the buffer each cycle
// EMIT   | streaming x beats out
module polar_encoder_seq
    import polar_enc_pkg::*;
#(
    parameter int NMAX_LOG = NMAX_LOG_DEF,
    parameter int NMIN_LOG = NMIN_LOG_DEF,
    parameter int P        = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    polar_encoder_seq_if.slave  bus
);
    localparam int W  = 1 << NMAX_LOG;
    localparam int BW = NMAX_LOG + 1;

    state_e          state_q;
    logic [3:0]      n_q;
    logic [3:0]      s_q;
    logic [BW-1:0]   k_q;
    logic [BW-1:0]   beats_q;
    logic [W-1:0]    buf_q;
    logic [W-1:0]    stage_out;
    logic [3:0]      n_eff;
    logic            start_go;
    logic            last_beat;

`ifdef POLAR_ENC_RANGE_CHK_EN
    logic n_ok;
    logic err_q;

    assign n_ok     = (bus.n >= 4'(NMIN_LOG)) && (bus.n <= 4'(NMAX_LOG));
    assign n_eff    = bus.n;
    assign start_go = bus.start_valid && n_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && bus.start_valid && !n_ok;
        end
    end
    assign bus.err = err_q;
`else
    always_comb begin
        if (bus.n < 4'(NMIN_LOG)) begin
            n_eff = 4'(NMIN_LOG);
        end else if (bus.n > 4'(NMAX_LOG)) begin
            n_eff = 4'(NMAX_LOG);
        end else begin
            n_eff = bus.n;
        end
    end
    assign start_go = bus.start_valid;
    assign bus.err  = 1'b0;
`endif

    polar_enc_stage #(.NMAX_LOG(NMAX_LOG)) u_stage (
        .x (buf_q),
        .s (s_q),
        .y (stage_out)
    );

    assign last_beat = (k_q == beats_q - 1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            s_q     <= '0;
            k_q     <= '0;
            beats_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_go) begin
                        state_q <= LOAD;
                        n_q     <= n_eff;
                        beats_q <= BW'(nbeats(n_eff, P));
                        k_q     <= '0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (last_beat) begin
                            state_q <= ENCODE;
                            k_q     <= '0;
                            s_q     <= '0;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                ENCODE: begin
                    s_q <= s_q + 4'd1;
                    if (s_q == n_q - 4'd1) begin
                        state_q <= EMIT;
                        s_q     <= '0;
                        k_q     <= '0;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (last_beat) begin
                            state_q <= IDLE;
                            k_q     <= '0;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset term.
    always_ff @(posedge clk_i) begin
        if (state_q == LOAD && bus.in_valid) begin
            buf_q[k_q*P +: P] <= bus.in_data;
        end else if (state_q == ENCODE) begin
            buf_q <= stage_out;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.in_ready    = (state_q == LOAD);
    assign bus.out_valid   = (state_q == EMIT);
    assign bus.out_last    = (state_q == EMIT) && last_beat;
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_data    = (state_q == EMIT) ? buf_q[k_q*P +: P] : '0;
endmodule

// File: tb/tb_polar_encoder_seq.sv
// Directed bench for polar_encoder_seq; reference encoder uses x[j] = XOR of u[i] over i containing j.
module tb_polar_encoder_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    polar_encoder_seq_if #(.P(32)) bus();

    polar_encoder_seq #(.NMAX_LOG(10), .NMIN_LOG(5), .P(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [1023:0] u_vec;
    logic [1023:0] got_vec;
    int got_beats, last_cnt, last_idx, lat;
    bit tmo;

    function automatic logic [1023:0] enc_model(input logic [1023:0] u, input int n);
        logic [1023:0] x;
        int nn;
        logic b;
        x = '0;
        nn = 1 << n;
        for (int j = 0; j < nn; j++) begin
            b = 1'b0;
            for (int i = 0; i < nn; i++) begin
                if ((i & j) == j) b = b ^ u[i];
            end
            x[j] = b;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] n);
        bus.n = n;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
    endtask

    task automatic send_u(input int beats);
        for (int k = 0; k < beats; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = u_vec[k*32 +: 32];
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Cycle count includes the cycle of the final input handshake.
    task automatic wait_valid(output int cyc, output bit to);
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        to = !bus.out_valid;
    endtask

    task automatic collect(input int beats);
        got_vec = '0;
        got_beats = 0;
        last_cnt = 0;
        last_idx = -1;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 400 && got_beats < beats; g++) begin
            if (bus.out_valid) begin
                got_vec[got_beats*32 +: 32] = bus.out_data;
                if (bus.out_last) begin
                    last_cnt++;
                    last_idx = got_beats;
                end
                got_beats++;
            end
            tick();
        end
    endtask

    task automatic run_frame(input logic [3:0] n, input int beats);
        do_start(n);
        send_u(beats);
        wait_valid(lat, tmo);
        collect(beats);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.start_ready, bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {bus.start_ready, bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.err});
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00000000", bus.out_data);
        end
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_ignored: busy=%b in_ready=%b expected 0/0", bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_n5();
        logic [31:0] uv [3] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0003};
        logic [31:0] ex [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002};
        for (int v = 0; v < 3; v++) begin
            u_vec = '0;
            u_vec[31:0] = uv[v];
            run_frame(4'd5, 1);
            checks++;
            if (tmo || lat !== 6) begin
                errors++;
                $display("FAIL n5_latency[%0d]: got %0d timeout=%0b expected 6", v, lat, tmo);
            end
            checks++;
            if (got_beats !== 1 || got_vec[31:0] !== ex[v]) begin
                errors++;
                $display("FAIL n5_data[%0d]: got %h (%0d beats) expected %h", v, got_vec[31:0], got_beats, ex[v]);
            end
            checks++;
            if (last_cnt !== 1 || last_idx !== 0) begin
                errors++;
                $display("FAIL n5_last[%0d]: count=%0d idx=%0d expected 1/0", v, last_cnt, last_idx);
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL n5_idle_after: out_valid=%b start_ready=%b expected 0/1", bus.out_valid, bus.start_ready);
        end
    endtask

    task automatic test_n6();
        u_vec = '0;
        u_vec[63] = 1'b1;
        run_frame(4'd6, 2);
        checks++;
        if (tmo || lat !== 7) begin
            errors++;
            $display("FAIL n6_latency: got %0d timeout=%0b expected 7", lat, tmo);
        end
        checks++;
        if (got_beats !== 2 || got_vec[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL n6_data: got %h (%0d beats) expected ffffffffffffffff", got_vec[63:0], got_beats);
        end
        checks++;
        if (last_cnt !== 1 || last_idx !== 1) begin
            errors++;
            $display("FAIL n6_last: count=%0d idx=%0d expected 1/1", last_cnt, last_idx);
        end
    endtask

    task automatic test_n10_random();
        logic [1023:0] exp_x;
        int bad;
        for (int w = 0; w < 32; w++) u_vec[w*32 +: 32] = $urandom;
        exp_x = enc_model(u_vec, 10);
        run_frame(4'd10, 32);
        bad = 0;
        for (int b = 0; b < 32; b++) begin
            if (got_vec[b*32 +: 32] !== exp_x[b*32 +: 32]) bad++;
        end
        checks++;
        if (tmo || got_beats !== 32 || bad !== 0) begin
            errors++;
            $display("FAIL n10_data: beats=%0d bad_beats=%0d timeout=%0b expected 32/0/0", got_beats, bad, tmo);
        end
        checks++;
        if (last_cnt !== 1 || last_idx !== 31) begin
            errors++;
            $display("FAIL n10_last: count=%0d idx=%0d expected 1/31", last_cnt, last_idx);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        u_vec = '0;
        u_vec[0]  = 1'b1;
        u_vec[63] = 1'b1;
        do_start(4'd6);
        send_u(2);
        wait_valid(lat, tmo);
        bus.out_ready = 1'b1;
        checks++;
        if (tmo || bus.out_data !== 32'hFFFF_FFFE || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_beat0: got %h last=%b expected fffffffe last=0", bus.out_data, bus.out_last);
        end
        tick();
        bus.out_ready = 1'b0;
        bus.n = 4'd5;
        bus.start_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFF || bus.out_last !== 1'b1
                || bus.start_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_stall_stable: %0d unstable cycles, data=%h expected 0", bad, bus.out_data);
        end
        bus.start_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: out_valid=%b busy=%b expected 0/0", bus.out_valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_start_ignored: busy=%b in_ready=%b expected 0/0", bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_emit();
        int extra;
        for (int w = 0; w < 4; w++) u_vec[w*32 +: 32] = $urandom;
        do_start(4'd7);
        send_u(4);
        wait_valid(lat, tmo);
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (tmo || {bus.start_ready, bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.err} !== 6'b100000
            || bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_emit_reset: flags=%b data=%h expected 100000/00000000",
                     {bus.start_ready, bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.err}, bus.out_data);
        end
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL mid_emit_no_more: got %0d output cycles expected 0", extra);
        end
        u_vec = '0;
        u_vec[31:0] = 32'hFFFF_FFFF;
        run_frame(4'd5, 1);
        checks++;
        if (tmo || got_beats !== 1 || got_vec[31:0] !== 32'h8000_0000 || last_cnt !== 1) begin
            errors++;
            $display("FAIL after_reset_frame: got %h beats=%0d last=%0d expected 80000000/1/1",
                     got_vec[31:0], got_beats, last_cnt);
        end
    endtask

    task automatic test_range();
`ifdef POLAR_ENC_RANGE_CHK_EN
        logic [3:0] bad_n [2] = '{4'd4, 4'd11};
        for (int v = 0; v < 2; v++) begin
            do_start(bad_n[v]);
            checks++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin
                errors++;
                $display("FAIL range_err_pulse[%0d]: err=%b busy=%b expected 1/0", v, bus.err, bus.busy);
            end
            tick();
            checks++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL range_err_clear[%0d]: err=%b busy=%b expected 0/0", v, bus.err, bus.busy);
            end
        end
`else
        logic [1023:0] exp_x;
        int bad;
        for (int w = 0; w < 32; w++) u_vec[w*32 +: 32] = $urandom;
        exp_x = enc_model(u_vec, 10);
        run_frame(4'd11, 32);
        bad = 0;
        for (int b = 0; b < 32; b++) begin
            if (got_vec[b*32 +: 32] !== exp_x[b*32 +: 32]) bad++;
        end
        checks++;
        if (tmo || got_beats !== 32 || bad !== 0 || last_idx !== 31) begin
            errors++;
            $display("FAIL clamp_n11: beats=%0d bad_beats=%0d last_idx=%0d expected 32/0/31", got_beats, bad, last_idx);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL clamp_err: got %b expected 0", bus.err);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.start_valid = 1'b0;
        bus.n = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        u_vec = '0;
        test_reset();
        test_n5();
        test_n6();
        test_n10_random();
        test_backpressure();
        test_reset_mid_emit();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
